// File: rtl/usb_cmd_pkg.sv
// rtl/usb_cmd_pkg.sv - shared constants and state type for the USB command decoder
package usb_cmd_pkg;

  localparam logic [7:0] CMD_SYNC  = 8'hA5;
  localparam logic [7:0] REG_CTRL  = 8'h00;
  localparam logic [7:0] REG_DECIM = 8'h01;
  localparam logic [7:0] EXT_BASE  = 8'h10;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    ADDR = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CSUM = 3'd4,
    EXEC = 3'd5
  } cmd_state_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] addr, input logic [15:0] data);
    return addr ^ data[15:8] ^ data[7:0];
  endfunction

endpackage

// File: rtl/usb_cmd_decoder_if.sv
// rtl/usb_cmd_decoder_if.sv - 8-bit command byte stream from the USB FIFO
interface usb_cmd_decoder_if;

  logic [7:0] cmd_tdata;
  logic       cmd_tvalid;
  logic       cmd_tready;

  modport master (
    output cmd_tdata,
    output cmd_tvalid,
    input  cmd_tready
  );

  modport slave (
    input  cmd_tdata,
    input  cmd_tvalid,
    output cmd_tready
  );

endinterface

// File: rtl/usb_cmd_decoder.sv
// rtl/usb_cmd_decoder.sv - parses 5-byte checksummed register-write frames
// and drives the local control registers plus an external write strobe.
module usb_cmd_decoder
  import usb_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  usb_cmd_decoder_if.slave         cmd,
  output logic                     stream_en,
  output logic                     channel_sel,
  output logic [15:0]              decim,
  output logic                     ext_wr_en,
  output logic [7:0]               ext_wr_addr,
  output logic [15:0]              ext_wr_data,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  cmd_state_t               state_q, state_d;
  logic [7:0]               addr_q, addr_d;
  logic [15:0]              data_q, data_d;
  logic [TO_W-1:0]          idle_q, idle_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic                     err_inc;
  logic                     accept;
  logic                     in_frame;
  logic                     exec_ctrl, exec_decim;

  assign cmd.cmd_tready = (state_q != EXEC);
  assign accept         = cmd.cmd_tvalid && cmd.cmd_tready;
  assign in_frame       = (state_q == ADDR) || (state_q == DHI) ||
                          (state_q == DLO)  || (state_q == CSUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      addr_q  <= '0;
      data_q  <= '0;
      idle_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idle_d  = '0;
    err_inc = 1'b0;

    unique case (state_q)
      HUNT: if (accept && cmd.cmd_tdata == CMD_SYNC) state_d = ADDR;
      ADDR: if (accept) begin
        addr_d  = cmd.cmd_tdata;
        state_d = DHI;
      end
      DHI: if (accept) begin
        data_d[15:8] = cmd.cmd_tdata;
        state_d      = DLO;
      end
      DLO: if (accept) begin
        data_d[7:0] = cmd.cmd_tdata;
        state_d     = CSUM;
      end
      CSUM: if (accept) begin
        if (cmd.cmd_tdata == frame_csum(addr_q, data_q)) begin
          state_d = EXEC;
        end else begin
          state_d = HUNT;
          err_inc = 1'b1;
        end
      end
      EXEC:    state_d = HUNT;
      default: state_d = HUNT;
    endcase

    // An accepted byte always beats expiry; the idle count only advances on stalls.
    if (in_frame && !accept) begin
      if (idle_q == TO_LAST) begin
        state_d = HUNT;
        err_inc = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    err_d = (err_inc && (err_q != '1)) ? err_q + 1'b1 : err_q;
  end

  assign exec_ctrl  = (state_q == EXEC) && (addr_q == REG_CTRL);
  assign exec_decim = (state_q == EXEC) && (addr_q == REG_DECIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      stream_en   <= 1'b0;
      channel_sel <= 1'b0;
      decim       <= '0;
    end else begin
      if (exec_ctrl) begin
        stream_en   <= data_q[0];
        channel_sel <= data_q[1];
      end
      if (exec_decim) decim <= data_q;
    end
  end

  // Gated by rst so a reset landing on EXEC never leaks an external write.
  assign ext_wr_en   = (state_q == EXEC) && (addr_q >= EXT_BASE) && !rst;
  assign ext_wr_addr = addr_q;
  assign ext_wr_data = data_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// tb/tb_usb_cmd_decoder.sv - directed and randomized checks against a frame-level model
module tb_usb_cmd_decoder;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        stream_en, channel_sel, ext_wr_en;
  logic [15:0] decim, ext_wr_data;
  logic [7:0]  ext_wr_addr, err_count;

  usb_cmd_decoder_if cmd_if ();

  usb_cmd_decoder #(.TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if.slave),
    .stream_en   (stream_en),
    .channel_sel (channel_sel),
    .decim       (decim),
    .ext_wr_en   (ext_wr_en),
    .ext_wr_addr (ext_wr_addr),
    .ext_wr_data (ext_wr_data),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level reference model
  bit          m_se, m_cs;
  bit [15:0]   m_decim;
  int          m_err;
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int          rdy_low_cycles;
  int          good_frames;

  always @(negedge clk) begin
    if (ext_wr_en === 1'b1) got_q.push_back({ext_wr_addr, ext_wr_data});
    if (rst === 1'b0 && cmd_if.cmd_tready === 1'b0) rdy_low_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_se = 0; m_cs = 0; m_decim = 0; m_err = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_if.cmd_tvalid = 1'b0;
    cmd_if.cmd_tdata  = 8'h00;
    idle(2);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic model_err();
    m_err = (m_err >= 255) ? 255 : m_err + 1;
  endtask

  task automatic model_frame(input bit [7:0] a, input bit [7:0] hi, input bit [7:0] lo, input bit [7:0] cs);
    if (cs == (a ^ hi ^ lo)) begin
      good_frames++;
      if (a == 8'h00) begin
        m_se = lo[0];
        m_cs = lo[1];
      end else if (a == 8'h01) begin
        m_decim = {hi, lo};
      end else if (a >= 8'h10) begin
        exp_q.push_back({a, hi, lo});
      end
    end else begin
      model_err();
    end
  endtask

  task automatic send_byte(input bit [7:0] b, input int gap);
    logic rdy;
    bit   done = 0;
    cmd_if.cmd_tvalid = 1'b0;
    idle(gap);
    cmd_if.cmd_tvalid = 1'b1;
    cmd_if.cmd_tdata  = b;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      rdy = cmd_if.cmd_tready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) done = 1;
    end
    cmd_if.cmd_tvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_byte_timeout observed=not-accepted expected=accepted byte=%0h", b);
    end
  endtask

  task automatic send_frame(input bit [7:0] a, input bit [15:0] d, input bit [7:0] cs, input int maxgap);
    send_byte(8'hA5, $urandom_range(maxgap));
    send_byte(a, $urandom_range(maxgap));
    send_byte(d[15:8], $urandom_range(maxgap));
    send_byte(d[7:0], $urandom_range(maxgap));
    send_byte(cs, $urandom_range(maxgap));
    model_frame(a, d[15:8], d[7:0], cs);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_stream_en"}, 32'(stream_en), 32'(m_se));
    check({tag, "_channel_sel"}, 32'(channel_sel), 32'(m_cs));
    check({tag, "_decim"}, 32'(decim), 32'(m_decim));
    check({tag, "_err_count"}, 32'(err_count), 32'(m_err));
  endtask

  task automatic compare_ext(input string tag);
    check({tag, "_ext_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_ext_item"}, 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    good_frames = 0;
    do_reset();
    check("reset_tready", 32'(cmd_if.cmd_tready), 32'd1);
    check("reset_ext_wr_en", 32'(ext_wr_en), 32'd0);
    check_regs("reset");

    // 1: control register
    send_frame(8'h00, 16'h0003, 8'h03, 0);
    idle(2);
    check_regs("t1");
    compare_ext("t1");

    // 2: decimation and external write
    send_frame(8'h01, 16'h1234, 8'h27, 0);
    idle(2);
    check_regs("t2_decim");
    send_frame(8'h10, 16'hBEEF, 8'h41, 0);
    idle(2);
    compare_ext("t2_ext");

    // 3: bad checksum then recovery
    send_frame(8'h01, 16'h0005, 8'h00, 0);
    idle(2);
    check_regs("t3_bad");
    send_frame(8'h01, 16'h0005, 8'h04, 0);
    idle(2);
    check_regs("t3_good");

    // 4: garbage in HUNT, sync byte as in-frame data
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    send_frame(8'h00, 16'h0000, 8'h00, 0);
    send_frame(8'hA5, 16'hA5A5, 8'hA5, 0);
    idle(2);
    check_regs("t4");
    compare_ext("t4");

    // 5: timeout exactly at expiry, byte on the expiry cycle, saturation
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    idle(TO);
    model_err();
    check_regs("t5_timeout");
    send_frame(8'h01, 16'h00AA, 8'hAB, 0);
    idle(2);
    check_regs("t5_after_timeout");
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    idle(TO - 1);
    send_byte(8'h0F, 0);
    send_byte(8'hF0, 0);
    send_byte(8'hFE, 0);
    model_frame(8'h01, 8'h0F, 8'hF0, 8'hFE);
    idle(2);
    check_regs("t5_expiry_accept");
    for (int i = 0; i < 300; i++) send_frame(8'h02, 16'h0000, 8'h55, 0);
    idle(2);
    check_regs("t5_saturate");
    check("t5_sat_value", 32'(err_count), 32'd255);

    // 6: randomized back-to-back frames with gaps
    do_reset();
    rdy_low_cycles = 0;
    good_frames = 0;
    for (int i = 0; i < 60; i++) begin
      bit [7:0]  a, cs;
      bit [15:0] d;
      int sel = $urandom_range(3);
      a  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : (sel == 2) ? 8'($urandom_range(15)) : 8'($urandom_range(255, 16));
      d  = 16'($urandom);
      cs = a ^ d[15:8] ^ d[7:0];
      if ($urandom_range(4) == 0) cs = cs ^ 8'($urandom_range(255, 1));
      send_frame(a, d, cs, 3);
    end
    idle(2);
    check_regs("t6_random");
    compare_ext("t6_random");
    check("t6_tready_low_cycles", 32'(rdy_low_cycles), 32'(good_frames));

    // reset mid-frame after DHI: partial frame dropped, no error
    send_frame(8'h00, 16'h0001, 8'h01, 0);
    idle(2);
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    send_byte(8'hBE, 0);
    do_reset();
    send_byte(8'hEF, 0);
    send_byte(8'h41, 0);
    idle(2);
    check_regs("t6_rst_mid");
    compare_ext("t6_rst_mid");

    // reset landing on EXEC suppresses the write
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    send_byte(8'h20, 0);
    do_reset();
    idle(2);
    check_regs("t6_rst_exec");
    compare_ext("t6_rst_exec");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
